// File: rtl/spi_slave_if_if.sv
// Core-side parallel bus of the SPI slave front-end.
// The slave modport is the SPI block; the master modport is the core logic.
interface spi_slave_if_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              underrun;
    logic              frame_abort;
    logic              busy;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        output underrun, frame_abort, busy,
        input  tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        input  underrun, frame_abort, busy,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// Oversampled SPI slave front-end: pins synchronised into clk, any mode,
// any width, either bit order, one-word TX holding register.
module spi_slave_if #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic nss,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    spi_slave_if_if.slave core
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic POL = (CPOL != 0);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   nss_prev_q, nss_prev_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   miso_q, miso_d;
    logic                   rx_pend_q, rx_pend_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   abort_q, abort_d;

    logic              sck_s, nss_s, mosi_s;
    logic              lead, trail, sample, shift, nss_fall;
    logic              load, start, hs;
    logic [DATA_W-1:0] rx_next, word;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign lead     = (sck_prev_q == POL) && (sck_s != POL);
    assign trail    = (sck_prev_q != POL) && (sck_s == POL);
    assign sample   = (CPHA == 0) ? lead : trail;
    assign shift    = (CPHA == 0) ? trail : lead;
    assign nss_fall = nss_prev_q && !nss_s;
    assign hs       = core.tx_valid && !hold_full_q;
    assign word     = hold_full_q ? hold_q : '0;
    assign rx_next  = (MSB_FIRST != 0) ? {rx_sr_q[DATA_W-2:0], mosi_s}
                                       : {mosi_s, rx_sr_q[DATA_W-1:1]};

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        nss_sync_d  = {nss_sync_q[SYNC_STAGES-2:0], nss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_s;
        nss_prev_d  = nss_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_pend_d   = 1'b0;
        rx_valid_d  = rx_pend_q;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;
        start       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                    start     = 1'b1;
                end
            end
            ACTIVE: begin
                // nss release wins over a sample landing in the same cycle
                if (nss_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                    abort_d   = (bit_cnt_q != '0);
                end else begin
                    if (sample) begin
                        rx_sr_d = rx_next;
                        if (bit_cnt_q == LAST) begin
                            bit_cnt_d = '0;
                            rx_data_d = rx_next;
                            rx_pend_d = 1'b1;
                            load      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (shift) begin
                        miso_d  = first_bit(tx_sr_q);
                        tx_sr_d = advance(tx_sr_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            hold_full_d = 1'b0;
            underrun_d  = !hold_full_q;
            if (start && (CPHA == 0)) begin
                miso_d  = first_bit(word);
                tx_sr_d = advance(word);
            end else begin
                tx_sr_d = word;
            end
        end
        // a same-cycle handshake lands after the load and is kept for the next word
        if (hs) begin
            hold_d      = core.tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sck_sync_q  <= {SYNC_STAGES{POL}};
            nss_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= POL;
            nss_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            nss_sync_q  <= nss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            nss_prev_q  <= nss_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_pend_q   <= rx_pend_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign miso             = miso_q;
    assign miso_oe          = (state_q == ACTIVE);
    assign core.rx_data     = rx_data_q;
    assign core.rx_valid    = rx_valid_q;
    assign core.tx_ready    = !hold_full_q;
    assign core.underrun    = underrun_q;
    assign core.frame_abort = abort_q;
    assign core.busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: three slaves (mode 0 MSB, mode 3 LSB, mode 1 MSB)
// driven by a bit-banged SPI master and checked against a word-level model.
module tb_spi_slave_if;
    localparam int W    = 8;
    localparam int HALF = 60;
    localparam logic [2:0] CPOL_V = 3'b010;
    localparam logic [2:0] CPHA_V = 3'b110;
    localparam logic [2:0] MSB_V  = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   sck_a, nss_a, mosi_a, miso_a, oe_a;
    logic [2:0]   rxv_a, rdy_a, un_a, ab_a, busy_a, tx_valid_a;
    logic [W-1:0] rx_data_a [3];
    logic [W-1:0] tx_data_a [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_slave_if_if #(.DATA_W(W)) bus();
        spi_slave_if #(
            .DATA_W(W),
            .CPOL(int'(CPOL_V[g])),
            .CPHA(int'(CPHA_V[g])),
            .MSB_FIRST(int'(MSB_V[g])),
            .SYNC_STAGES(2)
        ) dut (
            .clk(clk),
            .reset(reset),
            .sck(sck_a[g]),
            .nss(nss_a[g]),
            .mosi(mosi_a[g]),
            .miso(miso_a[g]),
            .miso_oe(oe_a[g]),
            .core(bus)
        );
        assign bus.tx_data  = tx_data_a[g];
        assign bus.tx_valid = tx_valid_a[g];
        assign rx_data_a[g] = bus.rx_data;
        assign rxv_a[g]     = bus.rx_valid;
        assign rdy_a[g]     = bus.tx_ready;
        assign un_a[g]      = bus.underrun;
        assign ab_a[g]      = bus.frame_abort;
        assign busy_a[g]    = bus.busy;
    end

    int checks = 0;
    int fails  = 0;
    int rxv_n [3];
    int un_n  [3];
    int ab_n  [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv_a[i]) rxv_n[i]++;
            if (un_a[i])  un_n[i]++;
            if (ab_a[i])  ab_n[i]++;
        end
    end

    // reference model: one-word holding buffer and expected pulse totals
    logic         hfull [3];
    logic [W-1:0] hval  [3];
    logic [W-1:0] rx_exp [3];
    int           un_exp [3];
    int           ab_exp [3];
    int           rxv_exp [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input int k, output logic [W-1:0] w);
        if (hfull[k]) begin
            w = hval[k];
            hfull[k] = 1'b0;
        end else begin
            w = '0;
            un_exp[k]++;
        end
    endtask

    task automatic preload(input int k, input logic [W-1:0] w);
        @(negedge clk);
        check("tx_ready_idle", rdy_a[k], 1);
        tx_data_a[k]  = w;
        tx_valid_a[k] = 1'b1;
        @(negedge clk);
        tx_valid_a[k] = 1'b0;
        check("tx_ready_full", rdy_a[k], 0);
        hfull[k] = 1'b1;
        hval[k]  = w;
    endtask

    task automatic xfer_word(input int k, input logic [W-1:0] w, input int nbits,
                             output logic [W-1:0] got);
        logic pol;
        int   b;
        pol = CPOL_V[k];
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            b = MSB_V[k] ? (W - 1 - i) : i;
            if (!CPHA_V[k]) begin
                mosi_a[k] = w[b];
                #(HALF);
                got[b] = miso_a[k];
                sck_a[k] = ~pol;
                #(HALF);
                sck_a[k] = pol;
            end else begin
                sck_a[k] = ~pol;
                mosi_a[k] = w[b];
                #(HALF);
                got[b] = miso_a[k];
                sck_a[k] = pol;
                #(HALF);
            end
        end
    endtask

    task automatic begin_frame(input int k, output logic [W-1:0] first);
        nss_a[k] = 1'b0;
        #(2 * HALF);
        model_load(k, first);
        check("busy_active", busy_a[k], 1);
        check("miso_oe_active", oe_a[k], 1);
        check("underrun_start", un_n[k], un_exp[k]);
    endtask

    task automatic wait_rx(input int k);
        int n;
        n = 0;
        while (rxv_n[k] < rxv_exp[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_count", rxv_n[k], rxv_exp[k]);
    endtask

    task automatic word(input int k, input logic [W-1:0] w, input logic [W-1:0] tx_exp,
                        output logic [W-1:0] next_exp);
        logic [W-1:0] got;
        xfer_word(k, w, W, got);
        check("miso_word", got, tx_exp);
        rxv_exp[k]++;
        rx_exp[k] = w;
        wait_rx(k);
        check("rx_data", rx_data_a[k], rx_exp[k]);
        model_load(k, next_exp);
        check("underrun_word", un_n[k], un_exp[k]);
    endtask

    task automatic end_frame(input int k, input int partial);
        nss_a[k] = 1'b1;
        #(2 * HALF);
        if (partial != 0) ab_exp[k]++;
        check("idle_state", {busy_a[k], oe_a[k], miso_a[k]}, 3'b000);
        check("frame_abort", ab_n[k], ab_exp[k]);
        check("rx_total", rxv_n[k], rxv_exp[k]);
        check("underrun_total", un_n[k], un_exp[k]);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check(tag, {miso_a[i], oe_a[i], rxv_a[i], rdy_a[i], un_a[i],
                        ab_a[i], busy_a[i], rx_data_a[i]}, {7'b0001000, 8'h00});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] e0, e1, e2, got;
        int k, nw;
        sck_a      = CPOL_V;
        nss_a      = '1;
        mosi_a     = '0;
        tx_valid_a = '0;
        for (int i = 0; i < 3; i++) begin
            tx_data_a[i] = '0;
            hfull[i]     = 1'b0;
            hval[i]      = '0;
            rx_exp[i]    = '0;
        end
        repeat (4) @(negedge clk);
        check_reset_state("reset_state");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // mode 0, MSB first
        preload(0, 8'h3C);
        begin_frame(0, e0);
        check("mode0_preload", e0, 8'h3C);
        word(0, 8'hA5, e0, e1);
        end_frame(0, 0);

        // mode 3, LSB first
        preload(1, 8'h81);
        begin_frame(1, e0);
        word(1, 8'h12, e0, e1);
        end_frame(1, 0);

        // two words, nss held low
        preload(0, 8'h11);
        begin_frame(0, e0);
        preload(0, 8'h22);
        word(0, 8'hF0, e0, e1);
        check("second_word_tx", e1, 8'h22);
        word(0, 8'h0F, e1, e2);
        end_frame(0, 0);

        // abort after 5 bits, then a clean frame
        preload(0, 8'h5C);
        begin_frame(0, e0);
        xfer_word(0, 8'hE7, 5, got);
        end_frame(0, 1);
        check("rx_after_abort", rx_data_a[0], 8'h0F);
        preload(0, 8'h69);
        begin_frame(0, e0);
        word(0, 8'hC4, e0, e1);
        end_frame(0, 0);

        // mode 1 with nothing preloaded
        begin_frame(2, e0);
        check("underrun_value", e0, 8'h00);
        word(2, 8'hB7, e0, e1);
        end_frame(2, 0);

        // reset after 4 bits
        preload(0, 8'hC3);
        begin_frame(0, e0);
        xfer_word(0, 8'h96, 4, got);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("reset_midframe");
        nss_a = '1;
        sck_a = CPOL_V;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hfull[i]  = 1'b0;
            rx_exp[i] = '0;
        end
        repeat (10) @(negedge clk);
        preload(0, 8'h77);
        begin_frame(0, e0);
        word(0, 8'h5A, e0, e1);
        end_frame(0, 0);

        // randomized frames on random slaves
        for (int f = 0; f < 6; f++) begin
            k  = int'($urandom_range(0, 2));
            nw = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) != 0) preload(k, W'($urandom));
            begin_frame(k, e0);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 3) != 0) preload(k, W'($urandom));
                word(k, W'($urandom), e0, e1);
                e0 = e1;
            end
            end_frame(k, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
